// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths and write-back entry type
package regfile_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_wb_queue_fifo.sv
// rtl/reg_wb_queue_fifo.sv - in-order write-back entry FIFO with visible contents
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  wb_entry_t               push_entry_i,
  input  logic                    pop_i,
  output wb_entry_t               head_o,
  output logic [CW-1:0]           count_o,
  output wb_entry_t [DEPTH-1:0]   entries_o,
  output logic [DEPTH-1:0]        valid_o
);

  logic [PW-1:0]          wptr_q, wptr_d;
  logic [PW-1:0]          rptr_q, rptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [DEPTH-1:0]       vld_q, vld_d;
  wb_entry_t [DEPTH-1:0]  mem_q;
  logic                   do_push, do_pop;

  // Guard locally so a misbehaving caller can never corrupt occupancy.
  assign do_push = push_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    vld_d   = vld_q;
    if (do_pop) begin
      rptr_d        = rptr_q + 1'b1;
      vld_d[rptr_q] = 1'b0;
    end
    if (do_push) begin
      wptr_d        = wptr_q + 1'b1;
      vld_d[wptr_q] = 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= push_entry_i;
    end
  end

  assign head_o    = mem_q[rptr_q];
  assign count_o   = count_q;
  assign entries_o = mem_q;
  assign valid_o   = vld_q;

endmodule

// File: rtl/reg_wb_queue.sv
// rtl/reg_wb_queue.sv - two-source write-back queue driving the register-file write port
module reg_wb_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  input  logic [AW-1:0] q1_addr,
  input  logic [AW-1:0] q2_addr,
  output logic          q1_pending,
  output logic          q2_pending,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [1:0]            starve_q, starve_d;
  logic                  b_force;
  logic                  a_xfer, b_xfer;
  logic                  push, pop;
  wb_entry_t             push_entry, head;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      vld;
  logic [CW-1:0]         fifo_count;

  logic                  wr_en_q, wr_en_d;
  logic [AW-1:0]         wr_addr_q, wr_addr_d;
  logic [DW-1:0]         wr_data_q, wr_data_d;
  logic                  q1_hit, q2_hit;

  assign full    = (fifo_count == CW'(DEPTH));
  assign empty   = (fifo_count == '0);
  assign count   = fifo_count;
  assign b_force = (starve_q == 2'd3);

  // A wins by default; B takes the slot once it has been passed over three times.
  assign a_ready = !full && !b_force;
  assign b_ready = !full && (!a_valid || b_force);
  assign a_xfer  = a_valid && a_ready;
  assign b_xfer  = b_valid && b_ready;

  always_comb begin
    push_entry = '0;
    push       = 1'b0;
    if (b_xfer) begin
      push_entry.addr = b_addr;
      push_entry.data = b_data;
      push            = (b_addr != REG_ZERO);
    end else if (a_xfer) begin
      push_entry.addr = a_addr;
      push_entry.data = a_data;
      push            = (a_addr != REG_ZERO);
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (b_xfer) begin
      starve_d = 2'd0;
    end else if (b_valid && !b_ready && !full) begin
      starve_d = starve_q + 2'd1;
    end
  end

  assign pop = !empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (fifo_count),
    .entries_o    (entries),
    .valid_o      (vld)
  );

  always_comb begin
    wr_en_d   = pop;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (pop) begin
      wr_addr_d = head.addr;
      wr_data_d = head.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q  <= 2'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      starve_q  <= starve_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  // A write is still pending while it sits in the FIFO or in the output register.
  always_comb begin
    q1_hit = wr_en_q && (wr_addr_q == q1_addr);
    q2_hit = wr_en_q && (wr_addr_q == q2_addr);
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (entries[i].addr == q1_addr)) q1_hit = 1'b1;
      if (vld[i] && (entries[i].addr == q2_addr)) q2_hit = 1'b1;
    end
  end

  assign q1_pending = q1_hit && (q1_addr != REG_ZERO);
  assign q2_pending = q2_hit && (q2_addr != REG_ZERO);

endmodule
